// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter driving the one-hot Sel of a 1-to-N SW demux, with break-before-make switching.
// Optional grant preemption after MAX_HOLD cycles is built only when ARB_TIMEOUT_EN is defined.
module demux_rr_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  input  logic                 din,
  output logic [N-1:0]         sel,
  output logic                 dout,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int ID_W = $clog2(N);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("demux_rr_arbiter: N must be in 2..8");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_hold
    $error("demux_rr_arbiter: MAX_HOLD must fit in HOLD_W bits");
  end

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    sel_q, sel_d;
  logic            dout_q, dout_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic            busy_q, busy_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] pick;
  logic            timeout;
  logic            release_c;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    return ID_W'((int'(base) + k) % N);
  endfunction

  // Scan from the farthest candidate inward so the one just after last_q wins;
  // last_q itself is visited at k=N and therefore has the lowest priority.
  always_comb begin
    pick = last_q;
    for (int k = N; k >= 1; k--) begin
      if (req[wrap_idx(last_q, k)]) pick = wrap_idx(last_q, k);
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Zero outside GRANT, so the count restarts at 0 on every grant entry.
  assign hold_d  = (state_q == GRANT) ? hold_q + HOLD_W'(1) : '0;
  assign timeout = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Any combination of owner done, owner request drop and timeout yields one release.
  assign release_c = done[gnt_id_q] | ~req[gnt_id_q] | timeout;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dout_d   = dout_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        if (|req) begin
          state_d     = GRANT;
          sel_d       = '0;
          sel_d[pick] = 1'b1;
          gnt_id_d    = pick;
          last_d      = pick;
          busy_d      = 1'b1;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = RELEASE;
          sel_d   = '0;
          dout_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          dout_d = din;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        dout_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      dout_q   <= 1'b0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      last_q   <= ID_W'(N - 1);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      dout_q   <= dout_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign sel    = sel_q;
  assign dout   = dout_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Self-checking bench for demux_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level owner/cooldown reference model.
module tb_demux_rr_arbiter;
  localparam int N        = 4;
  localparam int HOLD_W   = 8;
  localparam int MAX_HOLD = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, done;
  logic         din;
  logic [N-1:0] sel;
  logic         dout;
  logic [1:0]   gnt_id;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the path, whether the one-cycle gap is pending,
  // who won last, how many cycles the current grant has been visible.
  int m_owner;
  bit m_cool;
  int m_last;
  int m_held;
  bit m_dout;

  demux_rr_arbiter #(.N(N), .HOLD_W(HOLD_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .din(din),
    .sel(sel), .dout(dout), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cool  = 1'b0;
    m_last  = N - 1;
    m_held  = 0;
    m_dout  = 1'b0;
  endtask

  task automatic model_step();
    int r, d;
    bit rel;
    r = int'(req);
    d = int'(done);
    if (!rst_n) begin
      model_reset();
    end else if (m_owner >= 0) begin
      rel = (((d >> m_owner) & 1) == 1) || (((r >> m_owner) & 1) == 0);
`ifdef ARB_TIMEOUT_EN
      if (m_held == MAX_HOLD) rel = 1'b1;
`endif
      if (rel) begin
        m_owner = -1;
        m_cool  = 1'b1;
        m_dout  = 1'b0;
      end else begin
        m_dout = din;
        m_held++;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (r != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && ((r >> ((m_last + k) % N)) & 1) == 1) m_owner = (m_last + k) % N;
      end
      m_last = m_owner;
      m_held = 1;
      m_dout = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] es;
    es = '0;
    if (m_owner >= 0) es = N'(1) << m_owner;
    check({tag, ".sel"},  8'(sel),  8'(es));
    check({tag, ".busy"}, 8'(busy), 8'(m_owner >= 0));
    check({tag, ".dout"}, 8'(dout), 8'(m_dout));
    if (m_owner >= 0) check({tag, ".gnt_id"}, 8'(gnt_id), 8'(m_owner));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_outputs(tag);
  endtask

  initial begin
    logic [N-1:0] rot_exp [4];
    int n;
    rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1: reset holds everything low even with all requests up
    rst_n = 1'b0; req = 4'b1111; done = '0; din = 1'b0;
    model_reset();
    repeat (3) tick("reset");
    rst_n = 1'b1;
    tick("rst_release");
    check("t1_first_grant", 8'(sel), 8'h01);

    // 2: rotation with done pulsed three cycles into each grant
    for (int g = 0; g < 4; g++) begin
      tick("t2_hold");
      tick("t2_hold");
      done = N'(1) << m_owner;
      tick("t2_done");
      check("t2_released", 8'(sel), 8'h00);
      done = '0;
      tick("t2_gap");
      tick("t2_grant");
      check("t2_next", 8'(sel), 8'(rot_exp[g]));
    end

    // 3: single requester, dout follows din one cycle later, req drop releases
    req = '0;
    repeat (3) tick("t3_settle");
    req = 4'b0100;
    tick("t3_grant");
    check("t3_sel", 8'(sel), 8'h04);
    din = 1'b1; tick("t3_d1"); check("t3_dout1", 8'(dout), 8'h01);
    din = 1'b0; tick("t3_d0"); check("t3_dout0", 8'(dout), 8'h00);
    din = 1'b1; tick("t3_d1b"); check("t3_dout1b", 8'(dout), 8'h01);
    req = '0; din = 1'b0;
    tick("t3_drop");
    check("t3_sel_off", 8'(sel), 8'h00);
    repeat (2) tick("t3_idle");

    // 4: non-owner inputs ignored; simultaneous exit causes give one release
    req = 4'b0001;
    tick("t4_grant");
    check("t4_owner0", 8'(sel), 8'h01);
    req = 4'b1101;
    tick("t4_more");
    req = 4'b0101; done = 4'b0100;
    tick("t4_ignore");
    check("t4_ignored", 8'(sel), 8'h01);
    req = 4'b0100; done = 4'b0001;
    tick("t4_exit");
    check("t4_rel", 8'(sel), 8'h00);
    done = '0;
    tick("t4_gap");
    check("t4_gap_sel", 8'(sel), 8'h00);
    tick("t4_regrant");
    check("t4_regrant_sel", 8'(sel), 8'h04);

    // 5: asynchronous reset in the middle of index 2's grant
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_sel", 8'(sel), 8'h00);
    check("t5_async_busy", 8'(busy), 8'h00);
    model_reset();
    req = 4'b1111;
    tick("t5_in_reset");
    rst_n = 1'b1;
    tick("t5_restart");
    check("t5_restart_sel", 8'(sel), 8'h01);

    // 6: long hold with no done
    rst_n = 1'b0; req = 4'b0011;
    tick("t6_reset");
    rst_n = 1'b1;
    tick("t6_grant");
    n = 0;
    while (n < 130 && sel == 4'b0001) begin
      n++;
      tick("t6_hold");
    end
`ifdef ARB_TIMEOUT_EN
    check("t6_hold_len", 8'(n), 8'(MAX_HOLD));
    check("t6_pre_sel", 8'(sel), 8'h00);
    tick("t6_gap");
    tick("t6_next");
    check("t6_next_sel", 8'(sel), 8'h02);
`else
    check("t6_no_timeout", 8'(n >= 100), 8'h01);
`endif

    // Random traffic against the model
    req = '0; done = '0;
    repeat (3) tick("settle");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      done = ($urandom_range(7) == 0) ? N'(1) << $urandom_range(N - 1) : '0;
      din  = 1'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
